// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and limits for the mem_access_unit load/store bridge.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   // Reserved size is reported as misaligned so it shares the error path.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response and DataMem port bundle; master = core + RAM side, slave = the unit.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              addr_err;
   logic              ram_en;
   logic [3:0]        ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [31:0]       ram_dina;
   logic [31:0]       ram_douta;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_douta,
      input  req_ready, resp_valid, resp_rdata, addr_err, ram_en, ram_wea, ram_addra, ram_dina
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_douta,
      output req_ready, resp_valid, resp_rdata, addr_err, ram_en, ram_wea, ram_addra, ram_dina
   );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store strobes/replicated data and load extract/extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] douta,
   output logic [3:0]  wea,
   output logic [31:0] dina,
   output logic [31:0] rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = douta[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? douta[31:16] : douta[15:0];
      wea      = '0;
      dina     = '0;
      rdata    = '0;
      case (size)
         SZ_BYTE: begin
            wea   = 4'b0001 << addr_lo;
            dina  = {4{wdata[7:0]}};
            rdata = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            wea   = 4'b0011 << addr_lo;
            dina  = {2{wdata[15:0]}};
            rdata = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            wea   = 4'b1111;
            dina  = wdata;
            rdata = douta;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bridge between the core's valid/ready request and a synchronous single-port RAM.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned ADDR_W     = 32
) (
   input logic              clka,
   input logic              rst,
   mem_access_unit_if.slave bus
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        size_q;
   logic [1:0]        lo_q;
   logic              uns_q;
   logic              we_q;
   logic              ready_q;
   logic              resp_valid_q;
   logic              addr_err_q;
   logic [31:0]       resp_rdata_q;
   logic              ram_en_q;
   logic [3:0]        ram_wea_q;
   logic [ADDR_W-1:0] ram_addra_q;
   logic [31:0]       ram_dina_q;

   logic        idle;
   logic        accept;
   logic [1:0]  al_size;
   logic [1:0]  al_lo;
   logic [3:0]  al_wea;
   logic [31:0] al_dina;
   logic [31:0] al_rdata;

   assign idle   = (state_q == StIdle);
   assign accept = bus.req_valid && ready_q;

   // The single aligner sees the live request while idle and the latched one afterwards.
   assign al_size = idle ? bus.req_size : size_q;
   assign al_lo   = idle ? bus.req_addr[1:0] : lo_q;

   mem_lane_align u_align (
      .size       (al_size),
      .addr_lo    (al_lo),
      .is_unsigned(uns_q),
      .wdata      (bus.req_wdata),
      .douta      (bus.ram_douta),
      .wea        (al_wea),
      .dina       (al_dina),
      .rdata      (al_rdata)
   );

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         size_q       <= '0;
         lo_q         <= '0;
         uns_q        <= 1'b0;
         we_q         <= 1'b0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         ram_en_q     <= 1'b0;
         ram_wea_q    <= '0;
         ram_addra_q  <= '0;
         ram_dina_q   <= '0;
      end else begin
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_wea_q    <= '0;
         case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q <= 1'b0;
                  size_q  <= bus.req_size;
                  lo_q    <= bus.req_addr[1:0];
                  uns_q   <= bus.req_unsigned;
                  we_q    <= bus.req_we;
                  if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                     state_q      <= StDone;
                     resp_valid_q <= 1'b1;
                     addr_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q     <= StIssue;
                     ram_en_q    <= 1'b1;
                     ram_addra_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     if (bus.req_we) begin
                        ram_wea_q  <= al_wea;
                        ram_dina_q <= al_dina;
                     end
                  end
               end
            end
            StIssue: begin
               if (we_q) begin
                  state_q      <= StDone;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= '0;
               end else begin
                  state_q <= StWait;
                  cnt_q   <= CNT_W'(RD_LATENCY);
               end
            end
            StWait: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q      <= StDone;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= al_rdata;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.addr_err   = addr_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.ram_en     = ram_en_q;
   assign bus.ram_wea    = ram_wea_q;
   assign bus.ram_addra  = ram_addra_q;
   assign bus.ram_dina   = ram_dina_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store bridge between the mips core's memory request signals and the synchronous single-port DataMem.
- Stores: generates byte write strobes and lane-replicated write data for sb/sh/sw.
- Loads: waits out the RAM read latency, then extracts and sign/zero-extends lb/lbu/lh/lhu/lw data.
- Handshake: a valid/ready request and a one-cycle response pulse, so the core can stall on memory instead of assuming a combinational read.

Parameters:
RD_LATENCY, 1, cycles from the cycle ram_en is asserted to the cycle ram_douta holds valid data (legal 1..4).
ADDR_W, 32, byte-address width.

Ports:
clka  in  1  clock; all registers update on the rising edge.
rst  in  1  asynchronous reset, active high.
req_valid  in  1  core presents a request.
req_ready  out  1  unit can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
req_unsigned  in  1  zero-extend load data (lbu/lhu); ignored for word accesses and stores.
req_addr  in  ADDR_W  byte address (the core's aluout).
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
addr_err  out  1  qualifies resp_valid: misaligned address or reserved size.
ram_en  out  1  DataMem enable.
ram_wea  out  4  DataMem byte write enables.
ram_addra  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2], 2'b00}.
ram_dina  out  32  lane-replicated store data.
ram_douta  in  32  DataMem read data.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - req_ready, resp_valid, addr_err, ram_en = 0; ram_wea = 0.
  - resp_rdata, ram_addra, ram_dina = 0.
  - req_ready rises in the first cycle after rst deasserts.
- Reset mid-operation: the transaction is dropped and no response is issued. ram_en and ram_wea clear asynchronously, so no partial write happens after rst rises.
- FSM states: IDLE, ISSUE, WAIT, DONE. req_ready = 1 only in IDLE.
- IDLE: on req_valid && req_ready (cycle 0), register the request and check alignment.
  - Error case: size 11, halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - On error: go to DONE without touching the RAM; resp_valid and addr_err are asserted in cycle 1.
  - Otherwise go to ISSUE.
- ISSUE (cycle 1): the registered ram_en = 1, ram_addra, ram_wea and ram_dina are presented to the RAM.
  - Store: go to DONE.
  - Load: go to WAIT and load a latency counter with RD_LATENCY.
- WAIT: decrement the counter. In the cycle the counter reaches 1, capture ram_douta and go to DONE. ram_en = 0 during WAIT.
- DONE: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Latency from accept to resp_valid:
  - store: 2 cycles;
  - load: 2 + RD_LATENCY cycles (3 at the default);
  - error: 1 cycle.
  - Back-to-back requests: the earliest next accept is the cycle after resp_valid.
- Store lanes (little-endian):
  - byte: wea = 0001 << addr[1:0], dina = {4{wdata[7:0]}};
  - half: wea = 0011 << addr[1:0], dina = {2{wdata[15:0]}};
  - word: wea = 1111, dina = wdata.
- Load extract:
  - byte lane = addr[1:0]; halfword lane = addr[1].
  - Sign-extend unless req_unsigned; word loads pass through.
- resp_rdata holds its value until the next response. It is 0 on store and error responses.
- req_* inputs are sampled only at accept; changes afterwards are ignored.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD;
  - FSM state enum;
  - RD_LATENCY maximum constant.
- One combinational sub-module, mem_lane_align. It produces wea/dina from (size, addr[1:0], wdata) and the extended load data from (size, unsigned, addr[1:0], douta). It is instantiated once.

Test Plan:
- sw addr 0x10, data 0xDEADBEEF → in cycle 1: ram_en = 1, wea = 1111, addra = 0x10, dina = 0xDEADBEEF. resp_valid in cycle 2, addr_err = 0.
- sb addr 0x13, data 0x000000A5 → wea = 1000, dina = 0xA5A5A5A5. A following lw 0x10 returns 0xA5ADBEEF at cycle 3 after its accept.
- lb 0x13 after the above → resp_rdata 0xFFFFFFA5; lbu 0x13 → 0x000000A5; lh 0x12 → 0xFFFFA5AD; lhu 0x12 → 0x0000A5AD.
- lh addr 0x11, then sw addr 0x22 → each gives resp_valid with addr_err = 1 one cycle after accept. ram_en and wea stay 0 throughout; resp_rdata = 0.
- RD_LATENCY = 3, lw 0x10 → resp_valid exactly 5 cycles after accept. req_ready stays 0 until the cycle after resp_valid.
- rst pulsed during WAIT of a load → ram_en/wea = 0 immediately, no resp_valid, req_ready = 1 in the first cycle after release, and the next sw completes normally.
